// File: rtl/io_controller.sv
// Memory-mapped I/O unit: decodes the data-memory bus, holds the HEX/LEDR registers,
// and synchronizes plus debounces the KEY and SW board inputs.
module io_controller #(
    parameter int unsigned      DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_HEX        = DBITS'(32'hF000_0000),
    parameter logic [DBITS-1:0] ADDR_LEDR       = DBITS'(32'hF000_0004),
    parameter logic [DBITS-1:0] ADDR_KEY        = DBITS'(32'hF000_0010),
    parameter logic [DBITS-1:0] ADDR_SW         = DBITS'(32'hF000_0014),
    parameter int unsigned      DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             wrt_en,
    input  logic [DBITS-1:0] wrt_data,
    output logic [DBITS-1:0] rd_data,
    output logic             io_hit,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [9:0]       LEDR,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic        hit_hex, hit_ledr, hit_key, hit_sw;
    logic [15:0] hex_reg;
    logic [9:0]  ledr_reg;

    logic [3:0]    key_sync1, key_sync2, key_s, key_prev, key_stable;
    logic [CW-1:0] key_cnt;
    logic [9:0]    sw_sync1, sw_sync2, sw_prev, sw_stable;
    logic [CW-1:0] sw_cnt;

    logic unused_wrt_data;
    assign unused_wrt_data = ^wrt_data[DBITS-1:16];

    assign hit_hex  = (addr == ADDR_HEX);
    assign hit_ledr = (addr == ADDR_LEDR);
    assign hit_key  = (addr == ADDR_KEY);
    assign hit_sw   = (addr == ADDR_SW);
    assign io_hit   = hit_hex | hit_ledr | hit_key | hit_sw;

    // Zero-latency read mux into the core's load-result path
    always_comb begin
        rd_data = '0;
        if (hit_hex)       rd_data = DBITS'(hex_reg);
        else if (hit_ledr) rd_data = DBITS'(ledr_reg);
        else if (hit_key)  rd_data = DBITS'(key_stable);
        else if (hit_sw)   rd_data = DBITS'(sw_stable);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_reg  <= '0;
            ledr_reg <= '0;
        end else if (wrt_en) begin
            if (hit_hex)  hex_reg  <= wrt_data[15:0];
            if (hit_ledr) ledr_reg <= wrt_data[9:0];
        end
    end

    // Keys are active-low on the board; invert after sync so 1 = pressed
    assign key_s = ~key_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_sync1  <= 4'hF;
            key_sync2  <= 4'hF;
            key_prev   <= '0;
            key_stable <= '0;
            key_cnt    <= '0;
        end else begin
            key_sync1 <= KEY;
            key_sync2 <= key_sync1;
            key_prev  <= key_s;
            if (key_s != key_prev || key_s == key_stable) begin
                key_cnt <= '0;
            end else if (key_cnt == CNT_LAST) begin
                key_stable <= key_s;
                key_cnt    <= '0;
            end else begin
                key_cnt <= key_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_sync1  <= '0;
            sw_sync2  <= '0;
            sw_prev   <= '0;
            sw_stable <= '0;
            sw_cnt    <= '0;
        end else begin
            sw_sync1 <= SW;
            sw_sync2 <= sw_sync1;
            sw_prev  <= sw_sync2;
            if (sw_sync2 != sw_prev || sw_sync2 == sw_stable) begin
                sw_cnt <= '0;
            end else if (sw_cnt == CNT_LAST) begin
                sw_stable <= sw_sync2;
                sw_cnt    <= '0;
            end else begin
                sw_cnt <= sw_cnt + CW'(1);
            end
        end
    end

    // Active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign HEX0 = seg7(hex_reg[3:0]);
    assign HEX1 = seg7(hex_reg[7:4]);
    assign HEX2 = seg7(hex_reg[11:8]);
    assign HEX3 = seg7(hex_reg[15:12]);
    assign LEDR = ledr_reg;

endmodule
